// File: rtl/rf_wb_pkg.sv
// Shared constants for the register-file writeback arbiter: default widths,
// source indices and the hard-wired zero register address.
package rf_wb_pkg;

    localparam int RF_AW   = 5;
    localparam int RF_DW   = 32;
    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int X0_ADDR = 0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, ties go to the source that did
// not win most recently. The winner register starts at SRC_LSU so S0 wins first.
module rr_arb2
    import rf_wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == 1'(SRC_LSU)) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= 1'(SRC_LSU);
        end else if (|gnt) begin
            last <= gnt[SRC_LSU];
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the RF write port between the ALU (S0) and LSU (S1) writeback sources.
// Optional same-cycle read bypass is enabled by defining RF_WB_BYPASS_EN.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  logic [AW-1:0]    s0_addr,
    input  logic [DW-1:0]    s0_data,
    input  logic             s1_valid,
    output logic             s1_ready,
    input  logic [AW-1:0]    s1_addr,
    input  logic [DW-1:0]    s1_data,
    output logic             rf_we,
    output logic [AW-1:0]    rf_waddr,
    output logic [DW-1:0]    rf_wdata,
    output logic [CNT_W-1:0] wr_count,
    output logic             idle
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic             byp1_hit,
    output logic             byp2_hit,
    output logic [DW-1:0]    byp_data
`endif
);

    logic [1:0]       req_p0;
    logic [1:0]       gnt_p0;
    logic [AW-1:0]    addr_p0;
    logic [DW-1:0]    data_p0;
    logic             wr_p0;

    logic             vld_p1;
    logic [AW-1:0]    waddr_p1;
    logic [DW-1:0]    wdata_p1;
    logic [CNT_W-1:0] wr_cnt_q;

    // Stage p0: arbitration and winner select. Requests are masked in reset so
    // no source sees ready while the block is held.
    assign req_p0 = {s1_valid, s0_valid} & {2{rst}};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_p0),
        .gnt (gnt_p0)
    );

    assign s0_ready = gnt_p0[SRC_ALU];
    assign s1_ready = gnt_p0[SRC_LSU];
    assign addr_p0  = gnt_p0[SRC_LSU] ? s1_addr : s0_addr;
    assign data_p0  = gnt_p0[SRC_LSU] ? s1_data : s0_data;
    // x0 grants still complete the handshake but never reach the RF.
    assign wr_p0    = (|gnt_p0) && (addr_p0 != AW'(X0_ADDR));

    // Stage p1: registered write port; address/data hold when nothing is written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            wr_cnt_q <= '0;
        end else begin
            vld_p1 <= wr_p0;
            if (wr_p0) begin
                waddr_p1 <= addr_p0;
                wdata_p1 <= data_p0;
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
        end
    end

    assign rf_we    = vld_p1;
    assign rf_waddr = waddr_p1;
    assign rf_wdata = wdata_p1;
    assign wr_count = wr_cnt_q;
    assign idle     = !s0_valid && !s1_valid && !vld_p1;

`ifdef RF_WB_BYPASS_EN
    assign byp1_hit = vld_p1 && (ra1 != AW'(X0_ADDR)) && (ra1 == waddr_p1);
    assign byp2_hit = vld_p1 && (ra2 != AW'(X0_ADDR)) && (ra2 == waddr_p1);
    assign byp_data = wdata_p1;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter against a transaction-level model
// (winner history, expected write port state, accepted-write count).
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        s0_valid, s1_valid;
    logic        s0_ready, s1_ready;
    logic [4:0]  s0_addr, s1_addr;
    logic [31:0] s0_data, s1_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] wr_count;
    logic        idle;
`ifdef RF_WB_BYPASS_EN
    logic [4:0]  ra1, ra2;
    logic        byp1_hit, byp2_hit;
    logic [31:0] byp_data;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          last_src;
    bit          exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [31:0] exp_cnt;
    logic [31:0] rf_mem [32];

    rf_wb_arbiter #(.AW(5), .DW(32), .CNT_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_addr  (s0_addr),
        .s0_data  (s0_data),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_addr  (s1_addr),
        .s1_data  (s1_data),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .wr_count (wr_count),
        .idle     (idle)
`ifdef RF_WB_BYPASS_EN
        ,
        .ra1      (ra1),
        .ra2      (ra2),
        .byp1_hit (byp1_hit),
        .byp2_hit (byp2_hit),
        .byp_data (byp_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        last_src = 1;
        exp_we   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_cnt  = '0;
    endfunction

    // Which source should win given the current inputs: -1 none, 0 S0, 1 S1.
    function automatic int pick();
        if (!rst) return -1;
        if (s0_valid && s1_valid) return (last_src == 1) ? 0 : 1;
        if (s0_valid) return 0;
        if (s1_valid) return 1;
        return -1;
    endfunction

    // Advance one clock and move the model to the state after that edge.
    task automatic tick();
        int          g;
        logic [4:0]  a;
        logic [31:0] d;
        g = pick();
        a = (g == 1) ? s1_addr : s0_addr;
        d = (g == 1) ? s1_data : s0_data;
        @(posedge clk);
        exp_we = 1'b0;
        if (g >= 0) begin
            last_src = g;
            if (a != 5'd0) begin
                exp_we   = 1'b1;
                exp_addr = a;
                exp_data = d;
                exp_cnt  = exp_cnt + 32'd1;
                rf_mem[a] = d;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'h1111_0005;
        s1_valid = 1'b1; s1_addr = 5'd6; s1_data = 32'h2222_0006;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", rf_we); end
        checks++; if (wr_count !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", wr_count); end
        checks++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b want=00", s1_ready, s0_ready); end
        checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin failures++; $display("FAIL reset_regs got=%0d/%h want=0/0", rf_waddr, rf_wdata); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin failures++; $display("FAIL first_tie got=%b%b want=01", s1_ready, s0_ready); end
        tick();
        s0_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1111_0005) begin failures++; $display("FAIL first_write got=%b/%0d/%h want=1/5/11110005", rf_we, rf_waddr, rf_wdata); end
        #1;
        checks++; if (s1_ready !== 1'b1) begin failures++; $display("FAIL second_ready got=%b want=1", s1_ready); end
        tick();
        s1_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6) begin failures++; $display("FAIL second_write got=%b/%0d want=1/6", rf_we, rf_waddr); end
        tick();
        checks++; if (rf_we !== 1'b0 || wr_count !== 32'd2 || idle !== 1'b1) begin failures++; $display("FAIL post_idle got=%b/%0d/%b want=0/2/1", rf_we, wr_count, idle); end
    endtask

    task automatic test_single();
        s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (s0_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b want=1", s0_ready); end
        tick();
        s0_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_write got=%b/%0d/%h want=1/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
        tick();
        checks++; if (rf_we !== 1'b0 || rf_wdata !== 32'hDEAD_BEEF || wr_count !== exp_cnt) begin failures++; $display("FAIL single_after got=%b/%h/%0d want=0/deadbeef/%0d", rf_we, rf_wdata, wr_count, exp_cnt); end
    endtask

    task automatic test_x0();
        logic [31:0] cnt_before;
        cnt_before = wr_count;
        s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'h1234;
        #1;
        checks++; if (s1_ready !== 1'b1 || s0_ready !== 1'b0) begin failures++; $display("FAIL x0_ready got=%b%b want=10", s1_ready, s0_ready); end
        tick();
        s1_valid = 1'b0;
        checks++; if (rf_we !== 1'b0 || wr_count !== cnt_before || rf_waddr !== exp_addr || rf_wdata !== exp_data) begin failures++; $display("FAIL x0_squash got=%b/%0d/%0d/%h want=0/%0d/%0d/%h", rf_we, wr_count, rf_waddr, rf_wdata, cnt_before, exp_addr, exp_data); end
    endtask

    task automatic test_contention();
        s0_valid = 1'b1; s0_addr = 5'd3;
        s1_valid = 1'b1; s1_addr = 5'd4;
        for (int i = 0; i < 4; i++) begin
            s0_data = $urandom; s1_data = $urandom;
            #1;
            checks++; if (s0_ready !== (i % 2 == 0) || s1_ready !== (i % 2 == 1)) begin failures++; $display("FAIL contend_grant[%0d] got=%b%b want_src=%0d", i, s1_ready, s0_ready, i % 2); end
            tick();
            checks++; if (rf_we !== exp_we || rf_waddr !== exp_addr || rf_wdata !== exp_data) begin failures++; $display("FAIL contend_write[%0d] got=%b/%0d/%h want=%b/%0d/%h", i, rf_we, rf_waddr, rf_wdata, exp_we, exp_addr, exp_data); end
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        tick();
    endtask

    task automatic test_same_addr();
        // Establish S1 as the most recent winner so S0 wins the tie.
        s1_valid = 1'b1; s1_addr = 5'd0; s1_data = '0;
        tick();
        s0_valid = 1'b1; s0_addr = 5'd7; s0_data = 32'hA;
        s1_valid = 1'b1; s1_addr = 5'd7; s1_data = 32'hB;
        #1;
        checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin failures++; $display("FAIL same_first got=%b%b want=01", s1_ready, s0_ready); end
        tick();
        s0_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hA) begin failures++; $display("FAIL same_w1 got=%b/%0d/%h want=1/7/a", rf_we, rf_waddr, rf_wdata); end
        tick();
        s1_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hB) begin failures++; $display("FAIL same_w2 got=%b/%0d/%h want=1/7/b", rf_we, rf_waddr, rf_wdata); end
        tick();
        checks++; if (rf_mem[7] !== 32'hB || rf_we !== 1'b0) begin failures++; $display("FAIL same_final got=%h/%b want=b/0", rf_mem[7], rf_we); end
    endtask

    task automatic test_bypass();
`ifdef RF_WB_BYPASS_EN
        s0_valid = 1'b1; s0_addr = 5'd9; s0_data = 32'h55;
        tick();
        s0_valid = 1'b0;
        ra1 = 5'd9; ra2 = 5'd0;
        #1;
        checks++; if (byp1_hit !== 1'b1 || byp_data !== 32'h55 || byp2_hit !== 1'b0) begin failures++; $display("FAIL bypass_hit got=%b/%h/%b want=1/55/0", byp1_hit, byp_data, byp2_hit); end
        tick();
        checks++; if (byp1_hit !== 1'b0) begin failures++; $display("FAIL bypass_idle got=%b want=0", byp1_hit); end
        ra1 = '0;
`endif
    endtask

    task automatic test_wrap();
        force dut.wr_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        s1_valid = 1'b1; s1_addr = 5'd12; s1_data = 32'hC0FFEE;
        tick();
        s1_valid = 1'b0;
        checks++; if (wr_count !== 32'd0 || exp_cnt !== 32'd0) begin failures++; $display("FAIL wrap got=%0d want=0", wr_count); end
        tick();
    endtask

    task automatic test_reset_mid();
        s0_valid = 1'b1; s0_addr = 5'd10; s0_data = 32'hBAD0_0010;
        tick();
        s0_valid = 1'b0;
        checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b want=1", rf_we); end
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (rf_we !== 1'b0 || wr_count !== 32'd0 || rf_waddr !== 5'd0) begin failures++; $display("FAIL mid_drop got=%b/%0d/%0d want=0/0/0", rf_we, wr_count, rf_waddr); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mid_after got=%b want=0", rf_we); end
    endtask

    task automatic test_random();
        int g;
        for (int i = 0; i < 400; i++) begin
            if (!s0_valid && ($urandom % 3 != 0)) begin
                s0_valid = 1'b1; s0_addr = 5'($urandom); s0_data = $urandom;
            end
            if (!s1_valid && ($urandom % 3 != 0)) begin
                s1_valid = 1'b1; s1_addr = 5'($urandom % 16); s1_data = $urandom;
            end
            #1;
            g = pick();
            checks++; if (s0_ready !== (g == 0) || s1_ready !== (g == 1)) begin failures++; $display("FAIL rnd_grant[%0d] got=%b%b want_src=%0d", i, s1_ready, s0_ready, g); end
            tick();
            if (g == 0) s0_valid = 1'b0;
            if (g == 1) s1_valid = 1'b0;
            checks++; if (rf_we !== exp_we || rf_waddr !== exp_addr || rf_wdata !== exp_data || wr_count !== exp_cnt) begin failures++; $display("FAIL rnd_port[%0d] got=%b/%0d/%h/%0d want=%b/%0d/%h/%0d", i, rf_we, rf_waddr, rf_wdata, wr_count, exp_we, exp_addr, exp_data, exp_cnt); end
            #1;
            checks++; if (idle !== (!s0_valid && !s1_valid && !exp_we)) begin failures++; $display("FAIL rnd_idle[%0d] got=%b", i, idle); end
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        rst = 1'b0;
        s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
        s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
`ifdef RF_WB_BYPASS_EN
        ra1 = '0; ra2 = '0;
`endif
        test_reset();
        test_single();
        test_x0();
        test_contention();
        test_same_addr();
        test_bypass();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
